// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state and flag types for the alu_seq multi-cycle ALU.
// Signed opcodes exist only when ALU_SEQ_SIGNED_EN is defined.
package alu_seq_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT = 4'd5;
    localparam logic [OP_W-1:0] OP_LSH = 4'd6;
    localparam logic [OP_W-1:0] OP_RSH = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL = 4'd8;
    localparam logic [OP_W-1:0] OP_DIV = 4'd9;
    localparam logic [OP_W-1:0] OP_MOD = 4'd10;
`ifdef ALU_SEQ_SIGNED_EN
    localparam logic [OP_W-1:0] OP_ASR  = 4'd11;
    localparam logic [OP_W-1:0] OP_SDIV = 4'd12;
    localparam logic [OP_W-1:0] OP_SMOD = 4'd13;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic ge;
        logic set;
    } flags_t;

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        logic r;
        r = (op == OP_DIV) || (op == OP_MOD);
`ifdef ALU_SEQ_SIGNED_EN
        r = r || (op == OP_SDIV) || (op == OP_SMOD);
`endif
        return r;
    endfunction

endpackage

// File: rtl/divmod_seq.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle, WIDTH cycles total.
// The first iteration happens on the start edge so done pulses WIDTH-1 cycles later.
module divmod_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvs;

    // Shift the next dividend bit into the partial remainder and subtract if it fits.
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {r, q[WIDTH-1]};
        diff  = trial - {1'b0, d};
        if (diff[WIDTH])
            step = {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
        else
            step = {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                running <= 1'b1;
                cnt     <= CNT_W'(1);
            end else if (running) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            {rem, quo} <= step('0, a, b);
            dvs        <= b;
        end else if (running) begin
            {rem, quo} <= step(rem, quo, dvs);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready in and out: 1-cycle logic/arith, pipelined MUL, iterative DIV/MOD.
// Define ALU_SEQ_SIGNED_EN to add ASR, SDIV and SMOD.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_ge,
    output logic             out_set,
    output logic             out_dz,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH) + 1;

    state_t state, state_nxt;

    logic acc, take_one, take_mul, div_start;
    logic mul_done, div_done;

    logic [WIDTH-1:0] a_p0, b_p0;
    logic [OP_W-1:0]  op_p0;
    logic [TAG_W-1:0] tag_p0;
    flags_t           flg_p0, flg_out;

    logic [MUL_STAGES-1:0] mul_vld;
    logic [WIDTH-1:0]      mul_prod, mul_tail;

    logic [WIDTH-1:0] div_a, div_b, quo, rem, div_res;
`ifdef ALU_SEQ_SIGNED_EN
    logic neg_q_p0, neg_r_p0;
`endif

    function automatic flags_t cmp_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        flags_t f;
        f.eq  = (a == b);
        f.gt  = (a > b);
        f.ge  = (a >= b);
        f.set = ((a & b) != '0);
        return f;
    endfunction

    // Single-cycle results; DIV/MOD only reach here with a zero divisor.
    function automatic logic [WIDTH-1:0] alu1(input logic [OP_W-1:0]  op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic            big;
        logic [SH_W-2:0] amt;
        big = b[SH_W-1];
        amt = b[SH_W-2:0];
        case (op)
            OP_ADD:  alu1 = a + b;
            OP_SUB:  alu1 = a - b;
            OP_AND:  alu1 = a & b;
            OP_OR:   alu1 = a | b;
            OP_XOR:  alu1 = a ^ b;
            OP_NOT:  alu1 = ~a;
            OP_LSH:  alu1 = big ? '0 : (a << amt);
            OP_RSH:  alu1 = big ? '0 : (a >> amt);
            OP_DIV:  alu1 = '1;
            OP_MOD:  alu1 = a;
`ifdef ALU_SEQ_SIGNED_EN
            OP_ASR:  alu1 = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> amt);
            OP_SDIV: alu1 = '1;
            OP_SMOD: alu1 = a;
`endif
            default: alu1 = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take_mul)       state_nxt = S_MUL;
                else if (div_start) state_nxt = S_DIV;
            end
            S_MUL:   if (mul_done) state_nxt = S_IDLE;
            S_DIV:   if (div_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_rdy    = (state == S_IDLE) && (!out_vld || out_rdy);
        busy      = (state != S_IDLE);
        acc       = in_vld && in_rdy;
        take_mul  = acc && (in_op == OP_MUL);
        div_start = acc && is_div_op(in_op) && (in_B != '0);
        take_one  = acc && !take_mul && !div_start;
    end

    // Stage p0: operand capture at accept
    always_ff @(posedge clk) begin
        if (acc) begin
            a_p0   <= in_A;
            b_p0   <= in_B;
            op_p0  <= in_op;
            tag_p0 <= in_tag;
            flg_p0 <= cmp_flags(in_A, in_B);
`ifdef ALU_SEQ_SIGNED_EN
            neg_q_p0 <= in_A[WIDTH-1] ^ in_B[WIDTH-1];
            neg_r_p0 <= in_A[WIDTH-1];
`endif
        end
    end

    // Multiplier stages: product plus MUL_STAGES-1 registers, the result register is the last stage
    assign mul_prod = a_p0 * b_p0;

    if (MUL_STAGES == 1) begin : g_mul1
        assign mul_tail = mul_prod;
    end else begin : g_muln
        logic [WIDTH-1:0] mul_p [MUL_STAGES-1];
        always_ff @(posedge clk) begin
            mul_p[0] <= mul_prod;
            for (int i = 1; i < MUL_STAGES - 1; i++) mul_p[i] <= mul_p[i-1];
        end
        assign mul_tail = mul_p[MUL_STAGES-2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mul_vld <= '0;
        else      mul_vld <= (mul_vld << 1) | MUL_STAGES'(take_mul);
    end

    assign mul_done = mul_vld[MUL_STAGES-1];

    always_comb begin
        div_a = in_A;
        div_b = in_B;
`ifdef ALU_SEQ_SIGNED_EN
        if (in_op == OP_SDIV || in_op == OP_SMOD) begin
            div_a = in_A[WIDTH-1] ? -in_A : in_A;
            div_b = in_B[WIDTH-1] ? -in_B : in_B;
        end
`endif
    end

    divmod_seq #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (div_a),
        .b     (div_b),
        .quo   (quo),
        .rem   (rem),
        .done  (div_done)
    );

    // Sign correction applied in the done cycle so signed latency matches unsigned
    always_comb begin
        case (op_p0)
            OP_MOD:  div_res = rem;
`ifdef ALU_SEQ_SIGNED_EN
            OP_SDIV: div_res = neg_q_p0 ? -quo : quo;
            OP_SMOD: div_res = neg_r_p0 ? -rem : rem;
`endif
            default: div_res = quo;
        endcase
    end

    // Result register: loaded by whichever path completes, held until consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld <= 1'b0;
            out_res <= '0;
            out_tag <= '0;
            flg_out <= '0;
            out_dz  <= 1'b0;
        end else begin
            if (take_one) begin
                out_res <= alu1(in_op, in_A, in_B);
                out_tag <= in_tag;
                flg_out <= cmp_flags(in_A, in_B);
                out_dz  <= is_div_op(in_op);
            end else if (mul_done) begin
                out_res <= mul_tail;
                out_tag <= tag_p0;
                flg_out <= flg_p0;
                out_dz  <= 1'b0;
            end else if (div_done) begin
                out_res <= div_res;
                out_tag <= tag_p0;
                flg_out <= flg_p0;
                out_dz  <= 1'b0;
            end
            if (take_one || mul_done || div_done) out_vld <= 1'b1;
            else if (out_rdy)                     out_vld <= 1'b0;
        end
    end

    assign out_eq  = flg_out.eq;
    assign out_gt  = flg_out.gt;
    assign out_ge  = flg_out.ge;
    assign out_set = flg_out.set;

endmodule
